// File: rtl/pll_seq_pkg.sv
// ============================================================================
// Module      : pll_seq_pkg
// Description : Shared types and helpers for the PLL lock sequencer. Provides
//               the FSM state encoding and the counter-width helper that sizes
//               the single shared phase counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pll_seq_pkg;

  typedef enum logic [1:0] {
    ST_PLL_RST   = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STABLE    = 2'd2,
    ST_RUN       = 2'd3
  } pll_seq_state_t;

  // The counter only ever holds values up to (largest cycle count - 1), so
  // clog2 of the largest parameter is sufficient. Never narrower than 1 bit.
  function automatic int PLL_SEQ_CNT_W(input int unsigned rst_cycles,
                                       input int unsigned stable_cycles,
                                       input int unsigned timeout_cycles);
    int unsigned m;
    m = rst_cycles;
    if (stable_cycles > m) m = stable_cycles;
    if (timeout_cycles > m) m = timeout_cycles;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage : pll_seq_pkg

`default_nettype wire

// File: rtl/pll_seq_sync.sv
// ============================================================================
// Module      : pll_seq_sync
// Description : Two-flop synchroniser with synchronous active-low clear.
//               Brings the asynchronous PLL 'locked' flag into the reference
//               clock domain with two cycles of latency.
// Revision    : 1.0 - initial release
//
// Ports
//   clk_i   in  : destination clock
//   rst_ni  in  : synchronous active-low clear of both flops
//   d_i     in  : asynchronous input
//   q_o     out : synchronised output
// ============================================================================
`default_nettype none

module pll_seq_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule : pll_seq_sync

`default_nettype wire

// File: rtl/pll_lock_sequencer.sv
// ============================================================================
// Module      : pll_lock_sequencer
// Description : Reset and lock sequencer for the system PLL. Runs on the
//               50 MHz reference clock, pulses the PLL reset, synchronises and
//               qualifies 'locked', and releases the core reset request only
//               after lock has been continuously present for a programmed
//               number of cycles. Re-asserts core reset on lock loss.
// Revision    : 1.0 - initial release
//
// Build option
//   PLL_SEQ_AUTORETRY_EN : when defined, a lock timeout returns to PLL_RST and
//                          re-pulses the PLL reset indefinitely. When not
//                          defined, a timeout is flagged once and the FSM keeps
//                          waiting for lock.
//
// Ports
//   CLK_50M     in  : reference clock (same net as PLL refclk)
//   RESET_N     in  : synchronous active-low reset
//   pll_locked  in  : PLL locked flag, asynchronous to CLK_50M
//   pll_rst     out : PLL reset, active high
//   core_reset  out : core reset request, active high
//   ready       out : high while in RUN
//   lock_lost   out : one-cycle pulse when lock drops in RUN
//   timeout     out : sticky lock-timeout flag
//   retry_cnt   out : saturating count of lock timeouts
// ============================================================================
`default_nettype none

module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES     = 16,
  parameter int unsigned LOCK_STABLE_CYCLES = 4096,
  parameter int unsigned LOCK_TIMEOUT       = 1048576,
  parameter int unsigned RETRY_W            = 4
) (
  input  logic               CLK_50M,
  input  logic               RESET_N,
  input  logic               pll_locked,
  output logic               pll_rst,
  output logic               core_reset,
  output logic               ready,
  output logic               lock_lost,
  output logic               timeout,
  output logic [RETRY_W-1:0] retry_cnt
);

  localparam int CNT_W = PLL_SEQ_CNT_W(PLL_RST_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT);

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);

  logic lock_s;

  pll_seq_sync u_sync (
    .clk_i  (CLK_50M),
    .rst_ni (RESET_N),
    .d_i    (pll_locked),
    .q_o    (lock_s)
  );

  pll_seq_state_t     state_q,     state_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  // Set once a timeout has been reported in the current WAIT_LOCK visit so
  // that holding the counter at its terminal value does not re-fire it.
  logic               expired_q,   expired_d;
  logic               pll_rst_q,   pll_rst_d;
  logic               core_rst_q,  core_rst_d;
  logic               ready_q,     ready_d;
  logic               lock_lost_q, lock_lost_d;
  logic               timeout_q,   timeout_d;
  logic [RETRY_W-1:0] retry_q,     retry_d;

  always_ff @(posedge CLK_50M) begin
    if (!RESET_N) begin
      state_q     <= ST_PLL_RST;
      cnt_q       <= '0;
      expired_q   <= 1'b0;
      pll_rst_q   <= 1'b1;
      core_rst_q  <= 1'b1;
      ready_q     <= 1'b0;
      lock_lost_q <= 1'b0;
      timeout_q   <= 1'b0;
      retry_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      expired_q   <= expired_d;
      pll_rst_q   <= pll_rst_d;
      core_rst_q  <= core_rst_d;
      ready_q     <= ready_d;
      lock_lost_q <= lock_lost_d;
      timeout_q   <= timeout_d;
      retry_q     <= retry_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    expired_d   = expired_q;
    lock_lost_d = 1'b0;
    timeout_d   = timeout_q;
    retry_d     = retry_q;

    unique case (state_q)
      ST_PLL_RST: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
      end

      ST_WAIT_LOCK: begin
        // Lock arriving on the terminal cycle takes priority over timeout.
        if (lock_s) begin
          state_d = ST_STABLE;
        end else if (expired_q) begin
          cnt_d = cnt_q;
        end else if (cnt_q == TIMEOUT_LAST) begin
          timeout_d = 1'b1;
          if (retry_q != '1) retry_d = retry_q + RETRY_W'(1);
`ifdef PLL_SEQ_AUTORETRY_EN
          state_d   = ST_PLL_RST;
`else
          expired_d = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_STABLE: begin
        // Lock loss is checked first so it overrides count completion.
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RUN: begin
        if (!lock_s) begin
          state_d     = ST_WAIT_LOCK;
          lock_lost_d = 1'b1;
        end
      end

      default: state_d = ST_PLL_RST;
    endcase

    if (state_d != state_q) begin
      cnt_d     = '0;
      expired_d = 1'b0;
    end

    // Outputs are decoded from the next state so they register alongside it.
    pll_rst_d  = (state_d == ST_PLL_RST);
    core_rst_d = (state_d != ST_RUN);
    ready_d    = (state_d == ST_RUN);
  end

  assign pll_rst    = pll_rst_q;
  assign core_reset = core_rst_q;
  assign ready      = ready_q;
  assign lock_lost  = lock_lost_q;
  assign timeout    = timeout_q;
  assign retry_cnt  = retry_q;

endmodule : pll_lock_sequencer

`default_nettype wire
